// File: rtl/fir_pkg.sv
// Shared FIR datapath types and default sizes, used by the delay line,
// the MAC and the coefficient ROM.
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } dl_state_t;

  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_TAPS       = 8;

endpackage

// File: rtl/fir_tap_seq.sv
// Tap scan sequencer: owns the IDLE/SCAN state, the tap index and the
// upstream/MAC handshakes. All outputs except the hold mask are registered.
module fir_tap_seq
  import fir_pkg::*;
#(
  parameter  int TAPS      = FIR_TAPS,
  localparam int IDX_WIDTH = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_in_valid,
  input  logic                 i_hold,
  input  logic                 i_tap_ready,
  output logic                 o_in_ready,
  output logic                 o_accept,
  output logic                 o_tap_valid,
  output logic [IDX_WIDTH-1:0] o_tap_idx,
  output logic                 o_tap_last
);

  localparam logic [IDX_WIDTH-1:0] IDX_PENULT = IDX_WIDTH'(TAPS - 2);

  dl_state_t            r_state;
  logic                 r_in_ready;
  logic                 r_tap_valid;
  logic                 r_tap_last;
  logic [IDX_WIDTH-1:0] r_idx;

  // i_hold lets the top block acceptance (flush) without touching state.
  assign o_in_ready  = r_in_ready & ~i_hold;
  assign o_accept    = i_in_valid & o_in_ready;
  assign o_tap_valid = r_tap_valid;
  assign o_tap_idx   = r_idx;
  assign o_tap_last  = r_tap_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_tap_valid <= 1'b0;
      r_tap_last  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (o_accept) begin
        r_state     <= SCAN;
        r_idx       <= '0;
        r_in_ready  <= 1'b0;
        r_tap_valid <= 1'b1;
        r_tap_last  <= 1'b0;
      end
    end else if (i_tap_ready) begin
      if (r_tap_last) begin
        r_state     <= IDLE;
        r_idx       <= '0;
        r_in_ready  <= 1'b1;
        r_tap_valid <= 1'b0;
        r_tap_last  <= 1'b0;
      end else begin
        // tap_last is precomputed so it stays a plain register output
        r_idx      <= r_idx + IDX_WIDTH'(1);
        r_tap_last <= (r_idx == IDX_PENULT);
      end
    end
  end

endmodule

// File: rtl/fir_delay_line.sv
// FIR sample delay line: keeps the last TAPS samples and streams them newest
// first to a shared MAC. Define FIR_DELAY_LINE_FLUSH_EN to add a flush input.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter  int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter  int TAPS       = FIR_TAPS,
  localparam int IDX_WIDTH  = $clog2(TAPS),
  localparam int CNT_WIDTH  = $clog2(TAPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIR_DELAY_LINE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  tap_valid,
  input  logic                  tap_ready,
  output logic [DATA_WIDTH-1:0] tap_data,
  output logic [IDX_WIDTH-1:0]  tap_idx,
  output logic                  tap_last,
  output logic                  primed,
  output logic [CNT_WIDTH-1:0]  fill_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(TAPS);

  logic [DATA_WIDTH-1:0] r_taps [TAPS];
  logic [CNT_WIDTH-1:0]  r_fill_count;
  logic                  w_hold;
  logic                  w_accept;
  logic                  w_clear;

`ifdef FIR_DELAY_LINE_FLUSH_EN
  assign w_hold = flush;
`else
  assign w_hold = 1'b0;
`endif

  // Flush only acts while idle; tap_valid low is exactly the IDLE state.
  assign w_clear = w_hold & ~tap_valid;

  fir_tap_seq #(
    .TAPS (TAPS)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (in_valid),
    .i_hold      (w_hold),
    .i_tap_ready (tap_ready),
    .o_in_ready  (in_ready),
    .o_accept    (w_accept),
    .o_tap_valid (tap_valid),
    .o_tap_idx   (tap_idx),
    .o_tap_last  (tap_last)
  );

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
    end else if (w_accept) begin
      r_taps[0] <= in_data;
      for (int k = 1; k < TAPS; k++) r_taps[k] <= r_taps[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_fill_count <= '0;
    end else if (w_accept && (r_fill_count != CNT_FULL)) begin
      r_fill_count <= r_fill_count + CNT_WIDTH'(1);
    end
  end

  assign tap_data   = r_taps[tap_idx];
  assign fill_count = r_fill_count;
  assign primed     = (r_fill_count == CNT_FULL);

endmodule

// File: tb/tb_fir_delay_line.sv
// Scoreboard bench for fir_delay_line (TAPS=4, DATA_WIDTH=16); expected taps
// are queued when a sample is accepted and checked as the scan streams out.
module tb_fir_delay_line;

  localparam int DW   = 16;
  localparam int TAPS = 4;
  localparam int IW   = 2;
  localparam int CW   = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          tap_ready = 1'b1;

  logic          in_ready;
  logic          tap_valid;
  logic [DW-1:0] tap_data;
  logic [IW-1:0] tap_idx;
  logic          tap_last;
  logic          primed;
  logic [CW-1:0] fill_count;

  exp_t          exp_q[$];
  logic [DW-1:0] hist[TAPS];
  int            m_fill        = 0;
  int            total         = 0;
  int            bad           = 0;
  int            accept_cnt    = 0;
  int            scan_len      = 0;
  int            last_scan_len = 0;

  always #5 clk = ~clk;

  fir_delay_line #(
    .DATA_WIDTH (DW),
    .TAPS       (TAPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef FIR_DELAY_LINE_FLUSH_EN
    .flush      (flush),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tap_valid  (tap_valid),
    .tap_ready  (tap_ready),
    .tap_data   (tap_data),
    .tap_idx    (tap_idx),
    .tap_last   (tap_last),
    .primed     (primed),
    .fill_count (fill_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model, evaluated mid-cycle; its state updates describe the next edge.
  always @(negedge clk) begin : monitor
    bit   idle_now;
    exp_t e;
    idle_now = (exp_q.size() == 0);
    check_eq("in_ready", in_ready, idle_now && !flush);
    check_eq("tap_valid", tap_valid, !idle_now);
    check_eq("fill_count", fill_count, m_fill);
    check_eq("primed", primed, m_fill == TAPS);
    if (!idle_now) begin
      e = exp_q[0];
      check_eq("tap_data", tap_data, e.data);
      check_eq("tap_idx", tap_idx, e.idx);
      check_eq("tap_last", tap_last, e.last);
      scan_len++;
      if (tap_ready) begin
        void'(exp_q.pop_front());
        if (e.last) last_scan_len = scan_len;
      end
    end else begin
      check_eq("tap_last_idle", tap_last, 1'b0);
    end
    if (rst || (idle_now && flush)) begin
      exp_q.delete();
      for (int k = 0; k < TAPS; k++) hist[k] = '0;
      m_fill = 0;
    end else if (idle_now && in_valid) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_data;
      if (m_fill < TAPS) m_fill++;
      for (int k = 0; k < TAPS; k++) begin
        e.data = hist[k];
        e.idx  = IW'(k);
        e.last = (k == TAPS - 1);
        exp_q.push_back(e);
      end
      accept_cnt++;
      scan_len = 0;
      $display("accept data=%04h fill=%0d", in_data, m_fill);
    end
  end

  task automatic push(input logic [DW-1:0] d);
    int start;
    start    = accept_cnt;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (accept_cnt != start) break;
    end
    check_eq("push_accepted", accept_cnt - start, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_eq("idle_reached", exp_q.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < TAPS; k++) hist[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // single sample into empty history
    push(16'h0011);
    wait_idle();
    check_eq("t1_fill", fill_count, 1);

    // back-to-back pushes with in_valid held high
    for (int i = 1; i <= 5; i++) push(DW'(i));
    wait_idle();
    check_eq("t2_primed", primed, 1'b1);
    check_eq("t2_fill", fill_count, TAPS);

    // stall three cycles at idx 2
    push(16'h0A0A);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tap_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tap_ready = 1'b1;
    wait_idle();
    check_eq("stall_scan_len", last_scan_len, 7);

    // reset while scanning at idx 1
    push(16'h0033);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_tap_valid", tap_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_fill", fill_count, 0);
    push(16'h0077);
    wait_idle();

    // sample offered during a whole scan
    push(16'h0044);
    push(16'hBEEF);
    wait_idle();

    // random data with random MAC back-pressure
    for (int n = 0; n < 6; n++) begin
      push(DW'($urandom_range(0, 16'hFFFF)));
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
        tap_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      tap_ready = 1'b1;
      wait_idle();
    end

`ifdef FIR_DELAY_LINE_FLUSH_EN
    begin
      int start;
      check_eq("fl_primed_before", primed, 1'b1);
      start    = accept_cnt;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check_eq("fl_no_accept", accept_cnt - start, 0);
      check_eq("fl_fill", fill_count, 0);
      check_eq("fl_primed", primed, 1'b0);
      push(16'h00AB);
      wait_idle();
    end
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
